// File: rtl/row_scan_controller.sv
// row_scan_controller: sole driver of the 7442 row decoder select. Scans a
// ROWS x COLS switch matrix, synchronizes and debounces the active-low column
// returns, and publishes key press/release events over a valid/ready port.
//
//   state  | meaning
//   IDLE   | scan stopped, row_sel parked at 4'hF (no row driven)
//   SETTLE | row driven, letting columns settle through the synchronizer
//   SAMPLE | capture the row's synchronized, inverted column returns
//   EMIT   | debounce one column per cycle, possibly load one event
//   HOLD   | pad the row out to DWELL cycles, then advance or stop

module row_scan_controller #(
  parameter int ROWS     = 10,
  parameter int COLS     = 8,
  parameter int SETTLE   = 4,
  parameter int DWELL    = 16,
  parameter int DEBOUNCE = 3,
  localparam int KW      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic [3:0]           row_sel,
  input  logic [COLS-1:0]      col_n,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KW-1:0]        evt_key,
  output logic                 evt_press,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 frame_done
);

  localparam int NK  = ROWS * COLS;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RCW = $clog2(DWELL + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE_S = 3'd1;
  localparam logic [2:0] SAMPLE = 3'd2;
  localparam logic [2:0] EMIT   = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]      state;
  logic [3:0]      row;
  logic [3:0]      next_row;
  logic [RCW-1:0]  rc;
  logic [CW-1:0]   col;
  logic [COLS-1:0] sync1;
  logic [COLS-1:0] sync2;
  logic [COLS-1:0] row_raw;
  logic [2:0]      cnt [NK];
  logic [KW-1:0]   key_idx;
  logic            raw;
  logic            slot_free;
  logic            cnt_full;

  assign key_idx   = KW'(row) * KW'(COLS) + KW'(col);
  assign raw       = row_raw[col];
  assign slot_free = !evt_valid || evt_ready;
  // The key has now differed for DEBOUNCE consecutive scans.
  assign cnt_full  = ({1'b0, cnt[key_idx]} + 4'd1) >= 4'(DEBOUNCE);
  assign next_row  = (row == 4'(ROWS - 1)) ? 4'd0 : row + 4'd1;

  // Two-flop synchronizer for the asynchronous column returns (idle = released).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= col_n;
      sync2 <= sync1;
    end
  end

  // Row sequencer: every row lasts exactly DWELL cycles; enable only checked at row end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      row        <= '0;
      rc         <= '0;
      col        <= '0;
      row_sel    <= 4'hF;
      row_raw    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= SETTLE_S;
            row     <= '0;
            row_sel <= '0;
            rc      <= '0;
          end
        end
        SETTLE_S: begin
          rc <= rc + 1'b1;
          if (rc == RCW'(SETTLE - 1)) state <= SAMPLE;
        end
        SAMPLE: begin
          rc      <= rc + 1'b1;
          row_raw <= ~sync2;
          col     <= '0;
          state   <= EMIT;
        end
        EMIT: begin
          rc <= rc + 1'b1;
          if (col == CW'(COLS - 1)) state <= HOLD;
          else                      col   <= col + 1'b1;
        end
        HOLD: begin
          if (rc == RCW'(DWELL - 1)) begin
            rc  <= '0;
            row <= next_row;
            if (row == 4'(ROWS - 1)) frame_done <= 1'b1;
            if (enable) begin
              state   <= SETTLE_S;
              row_sel <= next_row;
            end else begin
              state   <= IDLE;
              row_sel <= 4'hF;
            end
          end else begin
            rc <= rc + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          row_sel <= 4'hF;
        end
      endcase
    end
  end

  // Per-key debounce and event slot; a key only toggles when its event is loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
      key_state <= '0;
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_press <= 1'b0;
    end else begin
      if (evt_valid && evt_ready) evt_valid <= 1'b0;
      if (state == EMIT) begin
        if (raw == key_state[key_idx]) begin
          cnt[key_idx] <= '0;
        end else if (!cnt_full) begin
          cnt[key_idx] <= cnt[key_idx] + 3'd1;
        end else if (slot_free) begin
          evt_key            <= key_idx;
          evt_press          <= raw;
          evt_valid          <= 1'b1;
          key_state[key_idx] <= ~key_state[key_idx];
          cnt[key_idx]       <= '0;
        end else begin
          // Slot busy: park at the threshold so the key retries next frame.
          cnt[key_idx] <= 3'(DEBOUNCE - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_row_scan_controller.sv
// Bench for row_scan_controller: table of single-key scenarios, random key
// traffic against a frame-level reference model, and hand-written sequences
// for backpressure, mid-row disable and asynchronous reset.

module tb_row_scan_controller;
  localparam int ROWS = 10;
  localparam int COLS = 8;
  localparam int NK   = ROWS * COLS;
  localparam int KW   = 7;
  localparam int DEB  = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            evt_ready = 1'b1;
  logic [3:0]      row_sel;
  logic [COLS-1:0] col_n;
  logic            evt_valid;
  logic [KW-1:0]   evt_key;
  logic            evt_press;
  logic [NK-1:0]   key_state;
  logic            frame_done;
  logic [NK-1:0]   pressed = '0;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct { int key; bit press; } evt_t;
  typedef struct { int key; int frames; bit press; int exp_evts; bit exp_state; } vec_t;

  evt_t act_q[$];
  evt_t exp_q[$];
  bit   m_st [NK];
  int   m_cnt[NK];
  bit   model_on = 1'b1;
  bit   vld_seen = 1'b0;
  bit   prev_stall = 1'b0;
  logic [KW-1:0] prev_key;
  logic prev_press;
  int   hit_key = -1;
  bit   hit_press = 1'b0;
  int   hit_cnt = 0;

  always #5 clk = ~clk;

  row_scan_controller #(.ROWS(ROWS), .COLS(COLS), .SETTLE(4), .DWELL(16), .DEBOUNCE(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .row_sel(row_sel), .col_n(col_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key), .evt_press(evt_press),
    .key_state(key_state), .frame_done(frame_done));

  // Switch matrix: a pressed key pulls its column low while its row is selected.
  always_comb begin
    col_n = '1;
    if (row_sel < 4'(ROWS))
      for (int c = 0; c < COLS; c++) col_n[c] = ~pressed[int'(row_sel) * COLS + c];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Observe transfers and payload stability mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", evt_valid, 1);
        chk("stall_key", evt_key, prev_key);
        chk("stall_press", evt_press, prev_press);
      end
      if (evt_valid) vld_seen = 1'b1;
      if (evt_valid && evt_ready) begin
        act_q.push_back('{int'(evt_key), evt_press});
        if (int'(evt_key) == hit_key && evt_press == hit_press) hit_cnt++;
      end
      prev_stall = evt_valid && !evt_ready;
      prev_key   = evt_key;
      prev_press = evt_press;
    end
  end

  // Reference: a key flips once its raw value has disagreed for DEB scans in a row.
  function automatic void model_frame(input logic [NK-1:0] p);
    for (int k = 0; k < NK; k++) begin
      if (p[k] == m_st[k]) m_cnt[k] = 0;
      else if (m_cnt[k] + 1 < DEB) m_cnt[k]++;
      else begin
        exp_q.push_back('{k, p[k]});
        m_st[k]  = p[k];
        m_cnt[k] = 0;
      end
    end
  endfunction

  task automatic next_frame();
    int t = 0;
    logic [NK-1:0] mv;
    while (t < 400) begin
      @(negedge clk);
      if (frame_done) break;
      t++;
    end
    if (t >= 400) chk("frame_timeout", 0, 1);
    if (model_on) begin
      model_frame(pressed);
      chk("evt_count", act_q.size(), exp_q.size());
      if (act_q.size() == exp_q.size())
        for (int i = 0; i < act_q.size(); i++) begin
          chk("evt_key", act_q[i].key, exp_q[i].key);
          chk("evt_dir", act_q[i].press, exp_q[i].press);
        end
      for (int k = 0; k < NK; k++) mv[k] = m_st[k];
      chk("key_state", key_state, mv);
      act_q.delete();
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[12];
    int   bad, fdbad, cnt, n4;
    vt[0]  = '{29, 3, 1'b1, 1, 1'b1};
    vt[1]  = '{29, 3, 1'b0, 1, 1'b0};
    vt[2]  = '{29, 2, 1'b1, 0, 1'b0};
    vt[3]  = '{29, 1, 1'b0, 0, 1'b0};
    vt[4]  = '{29, 2, 1'b1, 0, 1'b0};
    vt[5]  = '{29, 1, 1'b0, 0, 1'b0};
    vt[6]  = '{0,  3, 1'b1, 1, 1'b1};
    vt[7]  = '{0,  4, 1'b0, 1, 1'b0};
    vt[8]  = '{79, 3, 1'b1, 1, 1'b1};
    vt[9]  = '{79, 3, 1'b0, 1, 1'b0};
    vt[10] = '{30, 1, 1'b1, 0, 1'b0};
    vt[11] = '{30, 3, 1'b0, 0, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_sel", row_sel, 4'hF);
    chk("rst_valid", evt_valid, 0);
    chk("rst_key_state", key_state, 0);
    chk("rst_frame_done", frame_done, 0);
    reset_n = 1'b1;

    // Idle scan: row timing and frame period
    @(posedge clk); #1;
    enable = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      if (row_sel == 4'd0) break;
      cnt++;
    end
    chk("start_row0", row_sel, 0);
    fdbad = 0;
    for (int r = 0; r < ROWS; r++) begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (row_sel !== 4'(r)) bad++;
        if (frame_done !== 1'b0) fdbad++;
        @(negedge clk);
      end
      chk($sformatf("row_sel_row%0d", r), bad, 0);
    end
    chk("frame_done_160", frame_done, 1);
    chk("no_early_frame_done", fdbad, 0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_done && cnt < 400);
    chk("frame_period", cnt, 160);
    chk("no_evt_idle_keys", vld_seen, 0);
    @(posedge clk); #1;

    // Single-key scenario table
    for (int i = 0; i < 12; i++) begin
      pressed = '0;
      pressed[vt[i].key] = vt[i].press;
      hit_key = vt[i].key;
      hit_press = vt[i].press;
      hit_cnt = 0;
      for (int f = 0; f < vt[i].frames; f++) next_frame();
      chk($sformatf("vec%0d_events", i), hit_cnt, vt[i].exp_evts);
      chk($sformatf("vec%0d_state", i), key_state[vt[i].key], vt[i].exp_state);
    end
    hit_key = -1;

    // Random key traffic against the reference model
    for (int f = 0; f < 15; f++) begin
      for (int j = 0; j < 3; j++)
        if ($urandom_range(0, 1) == 1) begin
          int k;
          k = int'($urandom_range(0, NK - 1));
          pressed[k] = ~pressed[k];
        end
      next_frame();
    end
    pressed = '0;
    for (int f = 0; f < 4; f++) next_frame();
    model_on = 1'b0;

    // Backpressure: 29 held in the slot, 30 waits until it drains
    act_q.delete();
    pressed[29] = 1'b1;
    pressed[30] = 1'b1;
    evt_ready = 1'b0;
    for (int f = 0; f < 3; f++) next_frame();
    chk("bp_valid", evt_valid, 1);
    chk("bp_key", evt_key, 29);
    chk("bp_press", evt_press, 1);
    chk("bp_state29", key_state[29], 1);
    chk("bp_state30", key_state[30], 0);
    next_frame();
    chk("bp2_key", evt_key, 29);
    chk("bp2_state30", key_state[30], 0);
    chk("bp2_no_xfer", act_q.size(), 0);
    evt_ready = 1'b1;
    next_frame();
    chk("bp_xfer_count", act_q.size(), 2);
    if (act_q.size() == 2) begin
      chk("bp_first_key", act_q[0].key, 29);
      chk("bp_second_key", act_q[1].key, 30);
      chk("bp_second_dir", act_q[1].press, 1);
    end
    chk("bp_state30_after", key_state[30], 1);
    act_q.delete();
    next_frame();
    chk("bp_no_dup", act_q.size(), 0);

    // Drop enable during row 4
    cnt = 0;
    while (cnt < 400) begin
      @(negedge clk);
      if (row_sel == 4'd4) break;
      cnt++;
    end
    n4 = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) enable = 1'b0;
      if (row_sel != 4'd4) break;
      n4++;
    end
    chk("row4_len", n4, 16);
    chk("stop_row_sel", row_sel, 4'hF);
    chk("stop_no_frame_done", frame_done, 0);
    bad = 0;
    fdbad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_sel !== 4'hF) bad++;
      if (frame_done) fdbad++;
    end
    chk("idle_row_sel", bad, 0);
    chk("idle_no_frame_done", fdbad, 0);
    enable = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      if (row_sel != 4'hF) break;
      cnt++;
    end
    chk("restart_row0", row_sel, 0);

    // Asynchronous reset while an event is pending
    @(posedge clk); #1;
    evt_ready = 1'b0;
    pressed = '0;
    for (int f = 0; f < 3; f++) next_frame();
    chk("pre_rst_valid", evt_valid, 1);
    chk("pre_rst_key", evt_key, 29);
    chk("pre_rst_press", evt_press, 0);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_row_sel", row_sel, 4'hF);
    chk("arst_valid", evt_valid, 0);
    chk("arst_key", evt_key, 0);
    chk("arst_press", evt_press, 0);
    chk("arst_key_state", key_state, 0);
    chk("arst_frame_done", frame_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
